sort9_seq: RTL and testbench



---
 rtl/sort9_seq.sv | 176 +++++++++++++++++
 tb/tb_sort9_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sort9_seq.sv
// sort9_seq: sequential nine-entry odd-even transposition sorter.
// Captures nine values on start, runs nine compare/swap phases (one per
// cycle), then publishes the sorted vector with a snapshot of the input.
// Optional build macro: SORT_DESCENDING_EN selects descending order
// (sort1 holds the largest value); default build sorts ascending.
module sort9_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] arr1,
  input  logic [DATA_W-1:0] arr2,
  input  logic [DATA_W-1:0] arr3,
  input  logic [DATA_W-1:0] arr4,
  input  logic [DATA_W-1:0] arr5,
  input  logic [DATA_W-1:0] arr6,
  input  logic [DATA_W-1:0] arr7,
  input  logic [DATA_W-1:0] arr8,
  input  logic [DATA_W-1:0] arr9,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sort1,
  output logic [DATA_W-1:0] sort2,
  output logic [DATA_W-1:0] sort3,
  output logic [DATA_W-1:0] sort4,
  output logic [DATA_W-1:0] sort5,
  output logic [DATA_W-1:0] sort6,
  output logic [DATA_W-1:0] sort7,
  output logic [DATA_W-1:0] sort8,
  output logic [DATA_W-1:0] sort9,
  output logic [DATA_W-1:0] orig1,
  output logic [DATA_W-1:0] orig2,
  output logic [DATA_W-1:0] orig3,
  output logic [DATA_W-1:0] orig4,
  output logic [DATA_W-1:0] orig5,
  output logic [DATA_W-1:0] orig6,
  output logic [DATA_W-1:0] orig7,
  output logic [DATA_W-1:0] orig8,
  output logic [DATA_W-1:0] orig9
);

  typedef enum logic {IDLE, SORT} state_t;

  localparam logic [3:0] LAST_PHASE = 4'd8;

  state_t            state, state_next;
  logic              busy_next, done_next;
  logic              load, finish;
  logic [3:0]        phase;
  logic [DATA_W-1:0] arr_in [9];
  logic [DATA_W-1:0] w      [9];
  logic [DATA_W-1:0] c      [9];
  logic [DATA_W-1:0] ph     [9];
  logic [DATA_W-1:0] sort_q [9];
  logic [DATA_W-1:0] orig_q [9];

  assign arr_in = '{arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9};

  assign load   = (state == IDLE) && start;
  assign finish = (state == SORT) && (phase == LAST_PHASE);

  // True when a pair is out of order and must swap; equal values never swap.
  function automatic logic out_of_order(input logic [DATA_W-1:0] left,
                                        input logic [DATA_W-1:0] right);
`ifdef SORT_DESCENDING_EN
    return left < right;
`else
    return left > right;
`endif
  endfunction

  // One transposition phase: even phases pair (0,1)..(6,7), odd phases
  // pair (1,2)..(7,8); every compare reads pre-phase values.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned, which would infer a latch.
    ph = w;
    for (int p = 0; p < 4; p++) begin
      if (phase[0]) begin
        if (out_of_order(w[2*p+1], w[2*p+2])) begin
          ph[2*p+1] = w[2*p+2];
          ph[2*p+2] = w[2*p+1];
        end
      end else begin
        if (out_of_order(w[2*p], w[2*p+1])) begin
          ph[2*p]   = w[2*p+1];
          ph[2*p+1] = w[2*p];
        end
      end
    end
  end

  // FSM next-state and registered-output decode.
  always_comb begin
    state_next = state;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = SORT;
          busy_next  = 1'b1;
        end
      end
      SORT: begin
        if (phase == LAST_PHASE) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          busy_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state and handshake output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Datapath: capture on accept, one phase per SORT cycle, publish on the last phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these register arrays are reset explicitly because an aborted sort must leave every value at zero; they are flops, not RAM.
      w      <= '{default: '0};
      c      <= '{default: '0};
      sort_q <= '{default: '0};
      orig_q <= '{default: '0};
      phase  <= '0;
    end else if (load) begin
      w     <= arr_in;
      c     <= arr_in;
      phase <= '0;
    end else if (state == SORT) begin
      w <= ph;
      if (finish) begin
        sort_q <= ph;
        orig_q <= c;
        phase  <= '0;
      end else begin
        phase <= phase + 4'd1;
      end
    end
  end

  assign sort1 = sort_q[0];
  assign sort2 = sort_q[1];
  assign sort3 = sort_q[2];
  assign sort4 = sort_q[3];
  assign sort5 = sort_q[4];
  assign sort6 = sort_q[5];
  assign sort7 = sort_q[6];
  assign sort8 = sort_q[7];
  assign sort9 = sort_q[8];

  assign orig1 = orig_q[0];
  assign orig2 = orig_q[1];
  assign orig3 = orig_q[2];
  assign orig4 = orig_q[3];
  assign orig5 = orig_q[4];
  assign orig6 = orig_q[5];
  assign orig7 = orig_q[6];
  assign orig8 = orig_q[7];
  assign orig9 = orig_q[8];

endmodule

// File: tb/tb_sort9_seq.sv
// Self-checking bench for sort9_seq: scoreboard of expected sorted/original
// vectors, pushed when a start is accepted and popped on each done pulse.
module tb_sort9_seq;

  localparam int DATA_W = 8;
  localparam int VW     = 9 * DATA_W;

  typedef logic [VW-1:0] vec_t;
  typedef struct packed {
    vec_t sorted;
    vec_t orig;
  } exp_t;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] arr [9];
  logic              busy, done;
  logic [DATA_W-1:0] sort1, sort2, sort3, sort4, sort5, sort6, sort7, sort8, sort9;
  logic [DATA_W-1:0] orig1, orig2, orig3, orig4, orig5, orig6, orig7, orig8, orig9;
  vec_t              sort_v, orig_v;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  sort9_seq #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .arr1(arr[0]), .arr2(arr[1]), .arr3(arr[2]), .arr4(arr[3]), .arr5(arr[4]),
    .arr6(arr[5]), .arr7(arr[6]), .arr8(arr[7]), .arr9(arr[8]),
    .busy(busy), .done(done),
    .sort1(sort1), .sort2(sort2), .sort3(sort3), .sort4(sort4), .sort5(sort5),
    .sort6(sort6), .sort7(sort7), .sort8(sort8), .sort9(sort9),
    .orig1(orig1), .orig2(orig2), .orig3(orig3), .orig4(orig4), .orig5(orig5),
    .orig6(orig6), .orig7(orig7), .orig8(orig8), .orig9(orig9)
  );

  always #5 clk = ~clk;

  assign sort_v = {sort1, sort2, sort3, sort4, sort5, sort6, sort7, sort8, sort9};
  assign orig_v = {orig1, orig2, orig3, orig4, orig5, orig6, orig7, orig8, orig9};

  task automatic check(input string tag, input vec_t observed, input vec_t expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference order: plain bubble sort; element 0 (sort1) is the MSB slot.
  function automatic vec_t model_sort(input vec_t v);
    logic [DATA_W-1:0] a [9];
    logic [DATA_W-1:0] t;
    vec_t r;
    for (int i = 0; i < 9; i++) a[i] = v[VW-1-i*DATA_W -: DATA_W];
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
`ifdef SORT_DESCENDING_EN
        if (a[j] < a[j+1]) begin
`else
        if (a[j] > a[j+1]) begin
`endif
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
      end
    end
    for (int i = 0; i < 9; i++) r[VW-1-i*DATA_W -: DATA_W] = a[i];
    return r;
  endfunction

  task automatic set_arr(input vec_t v);
    for (int i = 0; i < 9; i++) arr[i] = v[VW-1-i*DATA_W -: DATA_W];
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 9; i++) v[VW-1-i*DATA_W -: DATA_W] = DATA_W'($urandom);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " unexpected done"}, vec_t'(done), vec_t'(0));
    end else begin
      e = sb.pop_front();
      check({tag, " sort"}, sort_v, e.sorted);
      check({tag, " orig"}, orig_v, e.orig);
    end
  endtask

  // Wait (bounded) for done, then score it.
  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    if (!done) check({tag, " timeout"}, vec_t'(done), vec_t'(1));
    else       compare_pop(tag);
  endtask

  // Full cycle-accurate transaction: accept at E0, busy E0..E8, done after E9.
  // A start pulse mid-sort must be ignored.
  task automatic run_directed(input string tag, input vec_t v);
    set_arr(v);
    start = 1'b1;
    sb.push_back(exp_t'{sorted: model_sort(v), orig: v});
    tick();
    start = 1'b0;
    set_arr(rand_vec());
    check({tag, " busy/done after accept"}, vec_t'({busy, done}), vec_t'(2'b10));
    for (int k = 1; k <= 8; k++) begin
      start = (k == 3);
      if (k == 3) set_arr(rand_vec());
      tick();
      check({tag, " busy/done mid-sort"}, vec_t'({busy, done}), vec_t'(2'b10));
    end
    start = 1'b0;
    tick();
    check({tag, " busy/done at completion"}, vec_t'({busy, done}), vec_t'(2'b01));
    compare_pop(tag);
    tick();
    check({tag, " busy/done after pulse"}, vec_t'({busy, done}), vec_t'(2'b00));
  endtask

  initial begin
    int pulses;
    set_arr('0);
    repeat (2) tick();
    check("reset busy/done", vec_t'({busy, done}), vec_t'(2'b00));
    check("reset sort", sort_v, '0);
    check("reset orig", orig_v, '0);
    rst_n = 1'b1;

    run_directed("reverse", {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    run_directed("presorted", {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9});
    run_directed("dups", {8'd5, 8'd3, 8'd5, 8'd0, 8'd255, 8'd3, 8'd0, 8'd255, 8'd5});

    // start held high, data changing every cycle: accepts at E0, E10, E20.
    for (int k = 0; k < 30; k++) begin
      set_arr(rand_vec());
      start = 1'b1;
      if (k % 10 == 0) begin
        sb.push_back(exp_t'{sorted: model_sort({arr[0], arr[1], arr[2], arr[3], arr[4],
                                                 arr[5], arr[6], arr[7], arr[8]}),
                            orig: {arr[0], arr[1], arr[2], arr[3], arr[4],
                                   arr[5], arr[6], arr[7], arr[8]}});
      end
      tick();
      check("stream done", vec_t'(done), vec_t'(k % 10 == 9));
      check("stream busy", vec_t'(busy), vec_t'(k % 10 != 9));
      if (done) compare_pop("stream");
    end
    start = 1'b0;
    tick();
    check("stream idle", vec_t'({busy, done}), vec_t'(2'b00));

    // Reset during phase 4 aborts the sort with no done pulse.
    set_arr(rand_vec());
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("abort busy/done", vec_t'({busy, done}), vec_t'(2'b00));
    check("abort sort", sort_v, '0);
    check("abort orig", orig_v, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) pulses++;
    end
    check("abort no done", vec_t'(pulses), vec_t'(0));

    run_directed("after abort", {8'd2, 8'd1, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9});
    run_directed("random a", rand_vec());

    // Back-to-back using the bounded wait path.
    set_arr(rand_vec());
    start = 1'b1;
    sb.push_back(exp_t'{sorted: model_sort({arr[0], arr[1], arr[2], arr[3], arr[4],
                                             arr[5], arr[6], arr[7], arr[8]}),
                        orig: {arr[0], arr[1], arr[2], arr[3], arr[4],
                               arr[5], arr[6], arr[7], arr[8]}});
    tick();
    start = 1'b0;
    wait_done("random b", 20);

    check("scoreboard empty", vec_t'(sb.size()), vec_t'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
